neuron_accum_seq: RTL and testbench

NEURON_ACCUM_SEQ -- requirements
Module: neuron_accum_seq

---
 rtl/neuro_accum_pkg.sv | 20 ++
 rtl/neuron_accum_seq_rr_arbiter.sv | 32 +++
 rtl/neuron_accum_seq.sv | 128 ++++++++++++
 tb/tb_neuron_accum_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/neuro_accum_pkg.sv
// Shared types and default parameters for the neuron accumulation sequencer.
// State encoding is fixed because it is visible to debug tooling.
`timescale 1ns/1ps
package neuro_accum_pkg;
    localparam int NUM_CH_DEF  = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 15;
    localparam int WD_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/neuron_accum_seq_rr_arbiter.sv
// Round-robin arbiter: lowest-offset requester at or after i_ptr wins.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic              o_valid,
    output logic [SEL_W-1:0]  o_grant
);
    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        int         idx;
        logic [SEL_W-1:0] w_idx;
        idx     = 0;
        w_idx   = '0;
        o_valid = 1'b0;
        o_grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(i_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            w_idx = SEL_W'(idx);
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_grant = w_idx;
            end
        end
    end
endmodule

// File: rtl/neuron_accum_seq.sv
// Neuron accumulation sequencer: issues num_adds adds over round-robin channels.
// Optional watchdog on add completion enabled by defining ADD_TIMEOUT_EN.
`timescale 1ns/1ps
module neuron_accum_seq
    import neuro_accum_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  num_adds,
    input  logic [NUM_CH-1:0] in_ready,
    input  logic              add_fin,
    output logic              start_add,
    output logic [SEL_W-1:0]  add_sel,
    output logic              all_adds_fin,
    output logic              busy,
    output logic [CNT_W-1:0]  add_count,
    output logic              timeout_err
);
    // state    | meaning
    // ST_IDLE  | waiting for frame_start
    // ST_ISSUE | arbitrating; launches an add as soon as any channel is ready
    // ST_WAIT  | add in flight, add_sel held until add_fin
    // ST_DONE  | one-cycle frame-complete pulse

    state_t           r_state;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_add_count;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_add_sel;
    logic             w_req_any;
    logic [SEL_W-1:0] w_winner;
    logic             w_grant;
    logic [CNT_W-1:0] w_next_count;
    logic             w_wd_expire;

    rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
        .i_req   (in_ready),
        .i_ptr   (r_ptr),
        .o_valid (w_req_any),
        .o_grant (w_winner)
    );

    assign w_grant      = (r_state == ST_ISSUE) && w_req_any;
    assign w_next_count = r_add_count + 1'b1;

    assign start_add    = w_grant;
    assign add_sel      = (r_state == ST_ISSUE) ? w_winner : r_add_sel;
    assign all_adds_fin = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE);
    assign add_count    = r_add_count;

`ifdef ADD_TIMEOUT_EN
    logic [WD_W-1:0] r_wd;
    logic            r_timeout_err;

    assign w_wd_expire = (r_state == ST_WAIT) && !add_fin && (r_wd == '0);
    assign timeout_err = r_timeout_err;

    // Down-counter reloaded on every grant; terminal count at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_wd <= WD_W'(TIMEOUT - 1);
            end else if ((r_state == ST_WAIT) && !add_fin && (r_wd != '0)) begin
                r_wd <= r_wd - 1'b1;
            end
            if ((r_state == ST_IDLE) && frame_start) begin
                r_timeout_err <= 1'b0;
            end else if (w_wd_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_wd_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            r_add_count <= '0;
            r_ptr       <= '0;
            r_add_sel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_add_count <= '0;
                        if (num_adds != '0) begin
                            r_target <= num_adds;
                            r_state  <= ST_ISSUE;
                        end else begin
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_grant) begin
                        r_add_sel <= w_winner;
                        r_ptr     <= (w_winner == SEL_W'(NUM_CH - 1)) ? '0 : w_winner + 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (add_fin) begin
                        r_add_count <= w_next_count;
                        r_state     <= (w_next_count == r_target) ? ST_DONE : ST_ISSUE;
                    end else if (w_wd_expire) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_accum_seq.sv
// Directed bench for neuron_accum_seq; watchdog cases follow ADD_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_neuron_accum_seq;
    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [CNT_W-1:0]  num_adds;
    logic [NUM_CH-1:0] in_ready;
    logic              add_fin;
    logic              start_add;
    logic [1:0]        add_sel;
    logic              all_adds_fin;
    logic              busy;
    logic [CNT_W-1:0]  add_count;
    logic              timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int g_starts, g_fin_cyc, g_cnt_at_fin, g_busy_at_fin, g_err_at_fin;
    int g_sels[$];
    int g_exp[$];

    always #5 clk = ~clk;

    neuron_accum_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .num_adds     (num_adds),
        .in_ready     (in_ready),
        .add_fin      (add_fin),
        .start_add    (start_add),
        .add_sel      (add_sel),
        .all_adds_fin (all_adds_fin),
        .busy         (busy),
        .add_count    (add_count),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_sels(input string tag);
        for (int i = 0; i < g_exp.size(); i++) begin
            check($sformatf("%s_sel%0d", tag, i), (i < g_sels.size()) ? g_sels[i] : -1, g_exp[i]);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        frame_start = 1'b0;
        num_adds    = '0;
        in_ready    = '0;
        add_fin     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Frame starts in cycle 0; the adder answers one cycle after each start_add.
    task automatic run_frame(input int n, input logic [3:0] rdy, input int hold_fin,
                             input int inject_cyc, input int max_cyc);
        bit pend;
        pend          = 1'b0;
        g_starts      = 0;
        g_fin_cyc     = -1;
        g_cnt_at_fin  = -1;
        g_busy_at_fin = -1;
        g_err_at_fin  = -1;
        g_sels.delete();
        @(posedge clk); #1;
        frame_start = 1'b1;
        num_adds    = CNT_W'(n);
        in_ready    = rdy;
        add_fin     = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            frame_start = (c == inject_cyc);
            if (c == inject_cyc) num_adds = CNT_W'(9);
            add_fin = pend && (hold_fin == 0);
            pend    = 1'b0;
            #3;
            if (start_add) begin
                g_starts++;
                g_sels.push_back(int'(add_sel));
                pend = 1'b1;
            end
            if (all_adds_fin) begin
                g_fin_cyc     = c;
                g_cnt_at_fin  = int'(add_count);
                g_busy_at_fin = int'(busy);
                g_err_at_fin  = int'(timeout_err);
                break;
            end
        end
        @(posedge clk); #1;
        frame_start = 1'b0;
        add_fin     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pulses;

        do_reset();
        check("rst_start_add", int'(start_add), 0);
        check("rst_add_sel", int'(add_sel), 0);
        check("rst_all_fin", int'(all_adds_fin), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_add_count", int'(add_count), 0);
        check("rst_timeout_err", int'(timeout_err), 0);

        run_frame(3, 4'b0001, 0, 0, 40);
        check("t1_starts", g_starts, 3);
        g_exp = '{0, 0, 0};
        check_sels("t1");
        check("t1_fin_cyc", g_fin_cyc, 7);
        check("t1_count", g_cnt_at_fin, 3);
        check("t1_busy_after", int'(busy), 0);

        do_reset();
        run_frame(4, 4'b1111, 0, 0, 40);
        check("t2_starts", g_starts, 4);
        g_exp = '{0, 1, 2, 3};
        check_sels("t2");
        check("t2_fin_cyc", g_fin_cyc, 9);
        check("t2_count", g_cnt_at_fin, 4);

        do_reset();
        run_frame(0, 4'b1111, 0, 0, 10);
        check("t3_starts", g_starts, 0);
        check("t3_fin_cyc", g_fin_cyc, 1);
        check("t3_busy_at_fin", g_busy_at_fin, 1);
        check("t3_busy_after", int'(busy), 0);

        do_reset();
        run_frame(2, 4'b0110, 0, 2, 40);
        check("t4_starts", g_starts, 2);
        g_exp = '{1, 2};
        check_sels("t4");
        check("t4_fin_cyc", g_fin_cyc, 5);
        check("t4_count", g_cnt_at_fin, 2);

        do_reset();
        run_frame(3, 4'b1001, 0, 0, 40);
        g_exp = '{0, 3, 0};
        check_sels("t5");
        check("t5_fin_cyc", g_fin_cyc, 7);

        do_reset();
        run_frame(5, 4'b0001, 0, 0, 5);
        check("t6_pre_busy", int'(busy), 1);
        check("t6_pre_count", int'(add_count), 2);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_count", int'(add_count), 0);
        check("t6_add_sel", int'(add_sel), 0);
        check("t6_start_add", int'(start_add), 0);
        check("t6_all_fin", int'(all_adds_fin), 0);
        @(posedge clk); #1 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (all_adds_fin) pulses++;
        end
        check("t6_no_fin_pulse", pulses, 0);

        do_reset();
        run_frame(1, 4'b0001, 1, 0, 30);
`ifdef ADD_TIMEOUT_EN
        check("t7_fin_cyc", g_fin_cyc, 2 + TIMEOUT);
        check("t7_err_at_fin", g_err_at_fin, 1);
        check("t7_err_held", int'(timeout_err), 1);
        run_frame(1, 4'b0001, 0, 0, 20);
        check("t7_next_fin_cyc", g_fin_cyc, 3);
        check("t7_err_cleared", g_err_at_fin, 0);
`else
        check("t7_no_fin", g_fin_cyc, -1);
        check("t7_busy", int'(busy), 1);
        check("t7_err", int'(timeout_err), 0);
        add_fin = 1'b1;
        @(posedge clk); #1 add_fin = 1'b0;
        check("t7_late_fin", int'(all_adds_fin), 1);
        check("t7_late_count", int'(add_count), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
